// File: rtl/mips_mem_arbiter_if.sv
// Core-side and memory-side bus of the unified-memory arbiter.
// slave is the arbiter's view; master is the core/memory environment.
interface mips_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter for MIPS fetch and load/store paths.
// Data has priority, bounded by a fetch starvation guard and an ack watchdog.
module mips_mem_arbiter #(
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 16
) (
    input logic               clk,
    input logic               rst_n,
    mips_mem_arbiter_if.slave bus
);
    localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          if_err_q, if_err_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          d_rvalid_q, d_rvalid_d;
    logic          d_err_q, d_err_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic busy;
    logic sel_i;
    logic sel_d;
    logic ack_hit;
    logic to_hit;

    // Data wins unless fetch is waiting and the streak is used up.
    always_comb begin
        busy    = (state_q != IDLE);
        sel_d   = !busy && bus.d_req &&
                  (!bus.if_req || (streak_q < STREAK_MAX));
        sel_i   = !busy && bus.if_req && !sel_d;
        ack_hit = busy && bus.mem_ack;
        to_hit  = busy && !bus.mem_ack && (wdog_q == WDOG_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sel_d) begin
                    state_d = BUSY_D;
                end else if (sel_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (ack_hit || to_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.if_gnt    = sel_i;
        bus.d_gnt     = sel_d;
        bus.mem_req   = busy;
        bus.mem_we    = busy & we_q;
        bus.mem_addr  = busy ? addr_q  : 32'h0;
        bus.mem_wdata = busy ? wdata_q : 32'h0;
        bus.mem_be    = busy ? be_q    : 4'h0;
        bus.if_rvalid = if_rvalid_q;
        bus.if_err    = if_err_q;
        bus.if_rdata  = if_rdata_q;
        bus.d_rvalid  = d_rvalid_q;
        bus.d_err     = d_err_q;
        bus.d_rdata   = d_rdata_q;
    end

    always_comb begin
        streak_d    = streak_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        wdog_d      = '0;
        if_rvalid_d = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = d_rdata_q;

        if (sel_d) begin
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            be_d    = bus.d_be;
            if (!bus.if_req) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + SW'(1);
            end
        end else if (sel_i) begin
            we_d     = 1'b0;
            addr_d   = bus.if_addr;
            wdata_d  = 32'h0;
            be_d     = 4'hF;
            streak_d = '0;
        end

        if (busy && !(ack_hit || to_hit)) begin
            wdog_d = wdog_q + WW'(1);
        end

        // Stores keep the last load data; a timeout returns zero.
        if (ack_hit || to_hit) begin
            if (state_q == BUSY_D) begin
                d_rvalid_d = 1'b1;
                d_err_d    = to_hit;
                if (to_hit) begin
                    d_rdata_d = 32'h0;
                end else if (!we_q) begin
                    d_rdata_d = bus.mem_rdata;
                end
            end else begin
                if_rvalid_d = 1'b1;
                if_err_d    = to_hit;
                if_rdata_d  = to_hit ? 32'h0 : bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q    <= '0;
            wdog_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= 32'h0;
        end else begin
            streak_q    <= streak_d;
            wdog_q      <= wdog_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            if_rvalid_q <= if_rvalid_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end
endmodule
